// File: rtl/mc14433_digit_scan.sv
// mc14433_digit_scan
// Output stage of the MC14433 model: holds the 3 1/2-digit BCD result of the
// conversion counter and scans it onto a 4-bit BCD bus with one-hot digit
// strobes (DS1 = MSD ... DS4 = LSD) and an active-low overrange flag.
module mc14433_digit_scan #(
  parameter int SCAN_DIV = 16,  // CP cycles per digit slot, blanking included
  parameter int BLANK    = 2    // blanking cycles at the start of each slot
) (
  input  logic       CP,
  input  logic       R,
  input  logic       EOC,
  input  logic       DU,
  input  logic [3:0] CNT_U,
  input  logic [3:0] CNT_T,
  input  logic [3:0] CNT_H,
  input  logic       CNT_K,
  input  logic       CNT_OVF,
  input  logic       POL,
  output logic [3:0] DS,
  output logic [3:0] Q,
  output logic       OR_N
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_P = PW'(BLANK);

  // Digit index doubles as the scan state; order matches the strobe order.
  typedef enum logic [1:0] {
    DIG_1 = 2'd0,
    DIG_2 = 2'd1,
    DIG_3 = 2'd2,
    DIG_4 = 2'd3
  } digit_e;

  // Result latch.
  logic [3:0] lat_u;
  logic [3:0] lat_t;
  logic [3:0] lat_h;
  logic       lat_k;
  logic       lat_ovf;
  logic       lat_pol;

  // Scan state.
  logic [PW-1:0] phase;
  digit_e        digit;

  // Strobe pattern and bus data for the current digit.
  logic [3:0] strobe;
  logic [3:0] slot_data;

  // Capture the counter result at end of conversion when updates are enabled.
  // NOTE: the reset is synchronous, so it is just the highest-priority branch
  // of the clocked block; an EOC coinciding with R is therefore ignored.
  always_ff @(posedge CP) begin
    if (R) begin
      lat_u   <= '0;
      lat_t   <= '0;
      lat_h   <= '0;
      lat_k   <= 1'b0;
      lat_ovf <= 1'b0;
      lat_pol <= 1'b0;
      OR_N    <= 1'b1;
    end else if (EOC && DU) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      lat_u   <= CNT_U;
      lat_t   <= CNT_T;
      lat_h   <= CNT_H;
      lat_k   <= CNT_K;
      lat_ovf <= CNT_OVF;
      lat_pol <= POL;
      OR_N    <= ~CNT_OVF;
    end
  end

  // Decode the current digit into its strobe and its bus content.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    strobe    = 4'b0000;
    slot_data = 4'b0000;
    unique case (digit)
      DIG_1: begin
        strobe    = 4'b0001;
        slot_data = {lat_k, lat_pol, 1'b0, lat_ovf};
      end
      DIG_2: begin
        strobe    = 4'b0010;
        slot_data = lat_h;
      end
      DIG_3: begin
        strobe    = 4'b0100;
        slot_data = lat_t;
      end
      DIG_4: begin
        strobe    = 4'b1000;
        slot_data = lat_u;
      end
    endcase
  end

  // Scan FSM: phase counter, digit advance on wrap, registered DS and Q.
  // DS goes active (and Q loads) on the edge that leaves phase BLANK and
  // drops on the edge that leaves phase 0; with BLANK=0 the load wins, so
  // the strobe moves straight to the next digit without a gap.
  always_ff @(posedge CP) begin
    if (R) begin
      phase <= '0;
      digit <= DIG_1;
      DS    <= 4'b0000;
      Q     <= 4'b0000;
    end else begin
      if (phase == LAST) begin
        phase <= '0;
        digit <= digit_e'(digit + 2'd1);
      end else begin
        phase <= phase + PW'(1);
      end

      if (phase == BLANK_P) begin
        DS <= strobe;
        Q  <= slot_data;
      end else if (phase == '0) begin
        DS <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_mc14433_digit_scan.sv
// Self-checking bench for mc14433_digit_scan.
// The stimulus process pushes hand-computed per-edge expectations into one
// queue per instance; independent monitors pop one entry per CP edge and
// compare DS, Q and OR_N. Instance a uses the default timing (16/2),
// instance b the gapless 4/0 configuration.
module tb_mc14433_digit_scan;

  typedef struct {
    logic [3:0] ds;
    logic [3:0] q;
    logic       or_n;
    int         k;
  } exp_t;

  logic       cp = 1'b0;
  logic       r;
  logic       r_b;
  logic       eoc;
  logic       du;
  logic [3:0] cnt_u;
  logic [3:0] cnt_t;
  logic [3:0] cnt_h;
  logic       cnt_k;
  logic       cnt_ovf;
  logic       pol;

  logic [3:0] ds_a;
  logic [3:0] q_a;
  logic       or_n_a;
  logic [3:0] ds_b;
  logic [3:0] q_b;
  logic       or_n_b;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   ka = -2;    // edge label: reset edges are -2..0, release edges 1..
  int   kb = -2;
  int   k_next = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 cp = ~cp;

  mc14433_digit_scan #(.SCAN_DIV(16), .BLANK(2)) dut_a (
    .CP(cp), .R(r), .EOC(eoc), .DU(du),
    .CNT_U(cnt_u), .CNT_T(cnt_t), .CNT_H(cnt_h), .CNT_K(cnt_k),
    .CNT_OVF(cnt_ovf), .POL(pol),
    .DS(ds_a), .Q(q_a), .OR_N(or_n_a)
  );

  mc14433_digit_scan #(.SCAN_DIV(4), .BLANK(0)) dut_b (
    .CP(cp), .R(r_b), .EOC(eoc), .DU(du),
    .CNT_U(cnt_u), .CNT_T(cnt_t), .CNT_H(cnt_h), .CNT_K(cnt_k),
    .CNT_OVF(cnt_ovf), .POL(pol),
    .DS(ds_b), .Q(q_b), .OR_N(or_n_b)
  );

  task automatic check(input string name, input int k,
                       input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b, expected %b", name, k, act, req);
    end
  endtask

  task automatic push_a(input logic [3:0] ds, input logic [3:0] q,
                        input logic or_n, input int n);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back('{ds: ds, q: q, or_n: or_n, k: ka});
      ka++;
    end
  endtask

  task automatic push_b(input logic [3:0] ds, input logic [3:0] q,
                        input logic or_n, input int n);
    for (int i = 0; i < n; i++) begin
      exp_b.push_back('{ds: ds, q: q, or_n: or_n, k: kb});
      kb++;
    end
  endtask

  // Advance to the falling edge just before release edge k.
  task automatic run_to(input int k);
    repeat (k - k_next) @(negedge cp);
    k_next = k;
  endtask

  task automatic set_cnt(input logic k, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] u, input logic p, input logic ovf);
    cnt_k   = k;
    cnt_h   = h;
    cnt_t   = t;
    cnt_u   = u;
    pol     = p;
    cnt_ovf = ovf;
  endtask

  // Monitor for instance a.
  initial begin
    exp_t e;
    forever begin
      @(posedge cp);
      #1;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("a.ds", e.k, ds_a, e.ds);
        check("a.q", e.k, q_a, e.q);
        check("a.or_n", e.k, {3'b000, or_n_a}, {3'b000, e.or_n});
      end
    end
  end

  // Monitor for instance b.
  initial begin
    exp_t e;
    forever begin
      @(posedge cp);
      #1;
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("b.ds", e.k, ds_b, e.ds);
        check("b.q", e.k, q_b, e.q);
        check("b.or_n", e.k, {3'b000, or_n_b}, {3'b000, e.or_n});
      end
    end
  end

  // Stimulus.
  initial begin
    int guard;

    // Reset held for 3 edges with random data and a qualifying EOC.
    r   = 1'b1;
    r_b = 1'b1;
    eoc = 1'b1;
    du  = 1'b1;
    set_cnt(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));
    push_a(4'b0000, 4'b0000, 1'b1, 3);
    push_b(4'b0000, 4'b0000, 1'b1, 3);
    repeat (3) @(negedge cp);
    r      = 1'b0;
    r_b    = 1'b0;
    eoc    = 1'b0;
    du     = 1'b0;
    k_next = 1;

    // Scan 1 (edges 1..64): cleared latch, every digit reads 0000.
    for (int d = 0; d < 4; d++) begin
      push_a(4'b0000, 4'b0000, 1'b1, 2);
      push_a(4'(1 << d), 4'b0000, 1'b1, 14);
    end
    // Gapless instance: two full scans, 4 edges per strobe, no blanking.
    for (int rep = 0; rep < 2; rep++)
      for (int d = 0; d < 4; d++)
        push_b(4'(1 << d), 4'b0000, 1'b1, 4);

    // Latch K=1 H=2 T=3 U=4 POL=1 OVF=0 late in the DS4 slot of scan 1.
    run_to(60);
    eoc = 1'b1;
    du  = 1'b1;
    set_cnt(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
    run_to(61);
    eoc = 1'b0;
    set_cnt(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 1'b1);

    // Scan 2 (edges 65..128).
    push_a(4'b0000, 4'b0000, 1'b1, 2);
    push_a(4'b0001, 4'b1100, 1'b1, 14);
    push_a(4'b0000, 4'b1100, 1'b1, 2);
    push_a(4'b0010, 4'b0010, 1'b1, 14);
    push_a(4'b0000, 4'b0010, 1'b1, 2);
    push_a(4'b0100, 4'b0011, 1'b1, 14);
    push_a(4'b0000, 4'b0011, 1'b1, 2);
    push_a(4'b1000, 4'b0100, 1'b1, 14);

    // EOC with DU=0 and 9/9/9, OVF=1 on the bus: latch and OR_N hold.
    run_to(70);
    eoc = 1'b1;
    du  = 1'b0;
    run_to(71);
    eoc = 1'b0;
    du  = 1'b1;   // DU high without EOC must not update either

    // Scan 3 (edges 129..192): EOC at 167 (U=5) and 168 (U=7), OVF=1,
    // both mid-DS3 slot; DS3 keeps 0011, OR_N drops at 167, DS4 shows 0111.
    push_a(4'b0000, 4'b0100, 1'b1, 2);
    push_a(4'b0001, 4'b1100, 1'b1, 14);
    push_a(4'b0000, 4'b1100, 1'b1, 2);
    push_a(4'b0010, 4'b0010, 1'b1, 14);
    push_a(4'b0000, 4'b0010, 1'b1, 2);
    push_a(4'b0100, 4'b0011, 1'b1, 4);
    push_a(4'b0100, 4'b0011, 1'b0, 10);
    push_a(4'b0000, 4'b0011, 1'b0, 2);
    push_a(4'b1000, 4'b0111, 1'b0, 14);

    run_to(167);
    eoc = 1'b1;
    du  = 1'b1;
    set_cnt(1'b1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b1);
    run_to(168);
    set_cnt(1'b1, 4'd2, 4'd3, 4'd7, 1'b1, 1'b1);
    run_to(169);
    eoc = 1'b0;
    set_cnt(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0);

    // Scan 4 (edges 193..249), reset at edge 250 inside the DS4 slot, then
    // a restart from DS1 with a cleared latch.
    push_a(4'b0000, 4'b0111, 1'b0, 2);
    push_a(4'b0001, 4'b1101, 1'b0, 14);
    push_a(4'b0000, 4'b1101, 1'b0, 2);
    push_a(4'b0010, 4'b0010, 1'b0, 14);
    push_a(4'b0000, 4'b0010, 1'b0, 2);
    push_a(4'b0100, 4'b0011, 1'b0, 14);
    push_a(4'b0000, 4'b0011, 1'b0, 2);
    push_a(4'b1000, 4'b0111, 1'b0, 7);
    push_a(4'b0000, 4'b0000, 1'b1, 1);    // edge 250: reset
    push_a(4'b0000, 4'b0000, 1'b1, 2);
    push_a(4'b0001, 4'b0000, 1'b1, 14);
    push_a(4'b0000, 4'b0000, 1'b1, 2);
    push_a(4'b0010, 4'b0000, 1'b1, 14);

    // Reset with a qualifying EOC on the same edge: reset wins.
    run_to(250);
    r   = 1'b1;
    eoc = 1'b1;
    du  = 1'b1;
    set_cnt(1'b1, 4'd8, 4'd8, 4'd8, 1'b1, 1'b1);
    run_to(251);
    r   = 1'b0;
    eoc = 1'b0;
    run_to(283);

    guard = 0;
    while ((exp_a.size() > 0 || exp_b.size() > 0) && guard < 1000) begin
      @(negedge cp);
      guard++;
    end
    if (exp_a.size() > 0 || exp_b.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0",
               exp_a.size() + exp_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc14433_digit_scan.md
# mc14433_digit_scan

Output stage of the MC14433 model: latches the 3½-digit BCD result of the conversion counter and time-multiplexes it onto a 4-bit BCD bus with one-hot digit strobes. It replaces the chip's result latch and digit-scan logic and drives the display/decoder interface (DS1–DS4, Q0–Q3, OR). A latch update occurs only at end of conversion and only when display update is enabled.

## Interface
- SCAN_DIV, 16: CP cycles per digit slot, including blanking; legal range 2–255.
- BLANK, 2: inter-digit blanking cycles at the start of each slot; legal range 0 to SCAN_DIV-1.

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- R  input  1  reset, synchronous, active-high.
- EOC  input  1  end-of-conversion pulse from conversion control, one CP wide.
- DU  input  1  display-update enable, level; sampled together with EOC.
- CNT_U  input  4  counter units digit, BCD.
- CNT_T  input  4  counter tens digit, BCD.
- CNT_H  input  4  counter hundreds digit, BCD.
- CNT_K  input  1  counter thousands (half) digit.
- CNT_OVF  input  1  counter overrange (count > 1999).
- POL  input  1  polarity of the conversion; 1 = positive.
- DS  output  4  digit strobes, one-hot or all-zero. DS[0]=DS1 (MSD) … DS[3]=DS4 (LSD).
- Q  output  4  multiplexed BCD data for the strobed digit.
- OR_N  output  1  latched overrange, active-low.

## Operation
- **Reset.** R=1 at an edge forces:
  - DS=0000, Q=0000, OR_N=1.
  - All latch registers to 0 (digits 0, K=0, OVF=0, POL=0).
  - Phase counter to 0 and digit index to DS1.
- **Latch.** At an edge with EOC=1 and DU=1, capture CNT_U, CNT_T, CNT_H, CNT_K, CNT_OVF and POL into the latch.
  - With EOC=1 and DU=0 the latch holds.
  - EOC=0 never updates the latch.
  - Non-BCD codes (>9) are latched and output unchanged; there is no range checking.
- **OR_N.** OR_N = ~latched OVF. It is registered and updates on the same edge as the latch.
- **Scan.**
  - A phase counter runs 0..SCAN_DIV-1 continuously. On wrap, the digit index advances DS1→DS2→DS3→DS4→DS1.
  - DS is registered. It is 0000 during phases 0..BLANK-1 of each slot and one-hot for the current digit during phases BLANK..SCAN_DIV-1.
- **Q loading.** Q is loaded at the edge where DS goes active for a slot and holds through the rest of the slot and the following blanking. With BLANK=0, Q is loaded at the first edge of the slot.
- **Q content per digit:**
  - DS1: Q3 = latched K, Q2 = latched POL, Q1 = 0, Q0 = latched OVF.
  - DS2: Q = latched H.
  - DS3: Q = latched T.
  - DS4: Q = latched U.
- **Latch update mid-slot.** Q of the current slot is unchanged; new data appears from the next slot's load. OR_N still updates immediately.
- **Latch event during reset.** R has priority. EOC at an edge with R=1 is ignored.

## Timing
- **First edges after R falls.** For BLANK edges, DS=0000. At edge BLANK+1, DS=0001 and Q holds the DS1 content.
- **Slot timing.**
  - DS stays active for SCAN_DIV-BLANK edges.
  - It then returns to 0000 for BLANK edges before the next strobe.
  - The full scan period is 4·SCAN_DIV CP cycles.
- **Strobe exclusivity.** No two DS bits are ever high together. DS changes only at slot boundaries.
- **Latency.**
  - EOC&DU sampled at edge n: latch and OR_N valid after edge n.
  - Q reflects the new data at the first strobe load after edge n; worst case SCAN_DIV cycles later.
- **Back-to-back EOC.** Each qualifying edge overwrites the latch; the last one wins.
- **Reset mid-scan.** Takes effect at the next edge. The scan restarts from phase 0 of DS1 with cleared latch.

## Test plan
1. **Reset.** Hold R=1 for 3 edges with random inputs and EOC=1 → DS=0000, Q=0000, OR_N=1. After release with default parameters: DS=0000 for 2 edges, then DS=0001 with Q=0000 for 14 edges.
2. **Basic latch and scan.** EOC=1, DU=1 with K=1, H=2, T=3, U=4, POL=1, OVF=0 → over the following scan:
   - DS1 slot: Q=1100.
   - DS2 slot: Q=0010.
   - DS3 slot: Q=0011.
   - DS4 slot: Q=0100.
   - OR_N=1.
   - Each strobe is 14 cycles high with 2 blank cycles between strobes.
3. **Update disabled.** After scenario 2, pulse EOC with DU=0 and inputs H=9, T=9, U=9, OVF=1 → Q sequence and OR_N unchanged.
4. **Overrange, mid-slot update.** During the DS3 slot, pulse EOC with DU=1 and OVF=1, U=7 → OR_N=0 the next cycle, Q stays 0011 for the remainder of DS3, and the DS4 slot shows 0111.
5. **BLANK=0, SCAN_DIV=4.** DS never reads 0000 after the first edge. The DS sequence is 0001×4, 0010×4, 0100×4, 1000×4, and repeats.
6. **Reset mid-scan.** Assert R during the DS4 slot for 1 edge → DS=0000, OR_N=1, latch cleared. The scan restarts at DS1 after BLANK edges with Q=0000.
